// File: rtl/apb_rr_master_if.sv
// Bundle of requester-side command/response signals and APB master signals for apb_rr_master.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_rr_master_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int PSTRB_WIDTH = DATA_WIDTH / 8;

  // Handshake: requester i's command transfers on the rising PCLK edge of a cycle with
  // req_valid[i] && req_ready[i]; req_ready is a one-hot, same-cycle grant, valid and payload
  // stay stable until then, and rsp_valid[i] is a one-cycle pulse with no back-pressure.
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata;
  logic [NUM_REQ*PSTRB_WIDTH-1:0] req_strb;
  logic [NUM_REQ*3-1:0]           req_prot;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_WIDTH-1:0]          rsp_rdata;
  logic                           rsp_err;
  logic                           rsp_timeout;

  logic                           PSELx;
  logic                           PENABLE;
  logic                           PWRITE;
  logic [ADDR_WIDTH-1:0]          PADDR;
  logic [DATA_WIDTH-1:0]          PWDATA;
  logic [PSTRB_WIDTH-1:0]         PSTRB;
  logic [2:0]                     PPROT;
  logic                           PREADY;
  logic                           PSLVERR;
  logic [DATA_WIDTH-1:0]          PRDATA;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin arbiter feeding a single APB master: one command in flight at a time,
// SETUP/ACCESS on the shared bus, one-cycle registered response to the owning requester.
module apb_rr_master #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_rr_master_if.master      bus,
  output logic [1:0]           dbg_state
);
  localparam int PSTRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WCW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic               grant_en;
  logic [WCW-1:0]     wait_cnt;
  logic               done_ok;
  logic               done_to;

  // Cyclic search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr;
    cand      = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant_en      = (state == S_IDLE) && gnt_found;
  assign bus.req_ready = (grant_en && PRESETn) ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign done_ok = (state == S_ACCESS) && bus.PREADY;
  assign done_to = (TIMEOUT != 0) && (state == S_ACCESS) && !bus.PREADY &&
                   (wait_cnt == WCW'(TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (gnt_found) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (done_ok || done_to) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign bus.PSELx   = (state == S_SETUP) || (state == S_ACCESS);
  assign bus.PENABLE = (state == S_ACCESS);
  assign dbg_state   = state;

  // The command latch doubles as the APB command outputs, so they hold between transfers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr             <= IDX_W'(NUM_REQ - 1);
      owner           <= '0;
      wait_cnt        <= '0;
      bus.PADDR       <= '0;
      bus.PWDATA      <= '0;
      bus.PSTRB       <= '0;
      bus.PPROT       <= '0;
      bus.PWRITE      <= 1'b0;
      bus.rsp_valid   <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid   <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      if (grant_en) begin
        ptr        <= gnt_idx;
        owner      <= gnt_idx;
        bus.PADDR  <= bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.PWDATA <= bus.req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        bus.PSTRB  <= bus.req_strb[int'(gnt_idx)*PSTRB_WIDTH +: PSTRB_WIDTH];
        bus.PPROT  <= bus.req_prot[int'(gnt_idx)*3 +: 3];
        bus.PWRITE <= bus.req_write[gnt_idx];
      end
      if (state == S_SETUP) wait_cnt <= '0;
      if (done_ok) begin
        bus.rsp_valid <= NUM_REQ'(1) << owner;
        bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
        bus.rsp_err   <= bus.PSLVERR;
      end else if (done_to) begin
        bus.rsp_valid   <= NUM_REQ'(1) << owner;
        bus.rsp_err     <= 1'b1;
        bus.rsp_timeout <= 1'b1;
      end else if ((state == S_ACCESS) && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: requester driver tasks, a reactive APB slave with a transaction-level
// reference model, and a response monitor popping an expected queue.
module tb_apb_rr_master;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int RW = 32 + NR + DW + 2;

  logic       PCLK;
  logic       PRESETn;
  logic [1:0] dbg_state;

  apb_rr_master_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_rr_master #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  // ---------------- counters and check ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s @cyc %0d: wait bound expired", name, cyc);
  endtask

  // ---------------- requester stimulus ----------------
  logic          cur_valid [NR];
  logic [AW-1:0] cur_addr  [NR];
  logic          cur_write [NR];
  logic [DW-1:0] cur_wdata [NR];
  logic [3:0]    cur_strb  [NR];
  logic [2:0]    cur_prot  [NR];

  always_comb begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_write = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]          = cur_valid[i];
      bus.req_addr[i*AW +: AW]  = cur_addr[i];
      bus.req_write[i]          = cur_write[i];
      bus.req_wdata[i*DW +: DW] = cur_wdata[i];
      bus.req_strb[i*4 +: 4]    = cur_strb[i];
      bus.req_prot[i*3 +: 3]    = cur_prot[i];
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake (plus gap idle cycles).
  task automatic issue(input int i, input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d,
                       input logic [3:0] s, input logic [2:0] p, input int gap);
    int  waited;
    bit  got;
    cur_addr[i]  = a;
    cur_write[i] = wr;
    cur_wdata[i] = d;
    cur_strb[i]  = s;
    cur_prot[i]  = p;
    cur_valid[i] = 1'b1;
    waited = 0;
    got    = 1'b0;
    while (!got && waited < 400) begin
      @(negedge PCLK);
      if (bus.req_ready[i]) got = 1'b1;
      else waited++;
    end
    if (!got) bound_fail($sformatf("handshake_req%0d", i));
    @(posedge PCLK); #1;
    if (gap > 0) begin
      cur_valid[i] = 1'b0;
      repeat (gap) @(posedge PCLK);
      #1;
    end
  endtask

  task automatic run_rand(input int i, input int n, input int maxgap);
    for (int t = 0; t < n; t++)
      issue(i, AW'($urandom), 1'($urandom), DW'($urandom), 4'($urandom), 3'($urandom),
            $urandom_range(0, maxgap));
    cur_valid[i] = 1'b0;
  endtask

  // ---------------- reference model + reactive APB slave ----------------
  logic [RW-1:0] exp_q[$];
  int            grant_log[$];
  int            phase = 0;          // 0 bus free, 1 setup due, 2 access
  int            ptr = NR - 1;
  int            owner = 0;
  logic [71:0]   last_cmd = '0;      // {addr, wdata, strb, prot, write}
  int            acc_n = 0;
  int            plan_wait = 0;
  bit            plan_err = 1'b0;
  logic [DW-1:0] plan_rdata = '0;
  int            n_grants = 0;
  int            n_aborted = 0;
  int            acc_seen = 0;

  int            sl_wait = 0;        // -1: random
  int            sl_err = 0;         // -1: random
  bit            sl_fix_rdata = 1'b0;
  logic [DW-1:0] sl_rdata = '0;
  bit            sl_noise_err = 1'b0;

  always @(negedge PCLK) begin
    int             next_phase;
    int             g;
    logic [NR-1:0]  exp_rdy;
    logic [71:0]    act_cmd;
    act_cmd = {bus.PADDR, bus.PWDATA, bus.PSTRB, bus.PPROT, bus.PWRITE};
    if (!PRESETn) begin
      check("rst_apb", {bus.PSELx, bus.PENABLE, act_cmd}, '0);
      check("rst_req_ready", bus.req_ready, '0);
      check("rst_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, '0);
      if (phase != 0) n_aborted++;
      phase    = 0;
      ptr      = NR - 1;
      last_cmd = '0;
      exp_q.delete();
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
      bus.PRDATA  = '0;
    end else begin
      check("psel", bus.PSELx, phase != 0);
      check("penable", bus.PENABLE, phase == 2);
      check(phase == 0 ? "cmd_hold" : "cmd_bus", act_cmd, last_cmd);
      if (bus.PSELx && !bus.PENABLE) acc_seen = 0;
      if (bus.PENABLE) acc_seen++;

      next_phase  = phase;
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = DW'($urandom);
      if (phase == 1) begin
        acc_n      = 0;
        plan_wait  = (sl_wait >= 0) ? sl_wait :
                     (($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 3));
        plan_err   = (sl_err >= 0) ? 1'(sl_err) : ($urandom_range(0, 3) == 0);
        plan_rdata = sl_fix_rdata ? sl_rdata : DW'($urandom);
        next_phase = 2;
      end else if (phase == 2) begin
        if (acc_n == plan_wait) begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = plan_err;
          bus.PRDATA  = plan_rdata;
          exp_q.push_back({32'(cyc + 1), NR'(1) << owner, last_cmd[0] ? '0 : plan_rdata,
                           plan_err, 1'b0});
          next_phase = 0;
        end else begin
          bus.PREADY = 1'b0;
          if (sl_noise_err) bus.PSLVERR = 1'b1;
          if (acc_n == TO - 1) begin
            exp_q.push_back({32'(cyc + 1), NR'(1) << owner, {DW{1'b0}}, 1'b1, 1'b1});
            next_phase = 0;
          end else begin
            acc_n++;
          end
        end
      end

      // Arbitration: the bus was free this cycle, so the first valid requester after ptr wins.
      exp_rdy = '0;
      g = -1;
      if (phase == 0) begin
        for (int k = 1; k <= NR; k++) begin
          if (g < 0 && cur_valid[(ptr + k) % NR]) g = (ptr + k) % NR;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      check("req_ready", bus.req_ready, exp_rdy);
      for (int i = NR - 1; i >= 0; i--) if (bus.req_ready[i]) begin
        grant_log.push_back(i);
        break;
      end
      if (g >= 0) begin
        ptr        = g;
        owner      = g;
        last_cmd   = {cur_addr[g], cur_wdata[g], cur_strb[g], cur_prot[g], cur_write[g]};
        next_phase = 1;
        n_grants++;
      end
      phase = next_phase;
    end
  end

  // ---------------- response monitor ----------------
  int            n_rsp_seen = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;
  logic          last_to = 1'b0;

  always @(negedge PCLK) begin
    logic [RW-1:0] e;
    if (PRESETn) begin
      if (bus.rsp_valid != '0) begin
        n_rsp_seen++;
        last_rdata = bus.rsp_rdata;
        last_err   = bus.rsp_err;
        last_to    = bus.rsp_timeout;
      end
      if ((exp_q.size() > 0 && int'(exp_q[0][RW-1 -: 32]) == cyc) || bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, '0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", 32'(cyc), e[RW-1 -: 32]);
          check("rsp_valid", bus.rsp_valid, e[DW+2 +: NR]);
          check("rsp_rdata", bus.rsp_rdata, e[2 +: DW]);
          check("rsp_err", bus.rsp_err, e[1]);
          check("rsp_timeout", bus.rsp_timeout, e[0]);
        end
      end else begin
        check("rsp_quiet", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, '0);
      end
    end
  end

  task automatic drain(input string name);
    int c;
    c = 0;
    while (!(phase == 0 && exp_q.size() == 0) && c < 300) begin
      @(negedge PCLK);
      c++;
    end
    if (c >= 300) bound_fail(name);
    @(posedge PCLK); #1;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    for (int i = 0; i < NR; i++) begin
      cur_valid[i] = 1'b0;
      cur_addr[i]  = '0;
      cur_write[i] = 1'b0;
      cur_wdata[i] = '0;
      cur_strb[i]  = '0;
      cur_prot[i]  = '0;
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    PRESETn     = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_dbg_state", dbg_state, 2'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Both requesters streaming: strict alternation starting at requester 0.
    grant_log.delete();
    sl_wait = -1; sl_err = 0;
    fork
      run_rand(0, 2, 0);
      run_rand(1, 2, 0);
    join
    drain("drain_rr");
    check("rr_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("rr_order_%0d", k), grant_log[k], k % 2);

    // Single write, zero wait.
    sl_wait = 0; sl_err = 0;
    issue(0, 32'h0000_0010, 1'b1, 32'hA5A5_1234, 4'hF, 3'd0, 1);
    drain("drain_write");
    check("wr_access_cycles", acc_seen, 1);
    check("wr_rdata_zero", last_rdata, 0);

    // Read with three wait cycles.
    sl_wait = 3; sl_fix_rdata = 1'b1; sl_rdata = 32'hDEAD_BEEF;
    issue(1, 32'h0000_0400, 1'b0, 32'h1111_2222, 4'h3, 3'd2, 1);
    drain("drain_read");
    check("rd_access_cycles", acc_seen, 4);
    check("rd_rdata", last_rdata, 32'hDEAD_BEEF);
    sl_fix_rdata = 1'b0;

    // PREADY never arrives: timeout abort after TO access cycles.
    sl_wait = 99;
    issue(0, 32'h0000_0800, 1'b0, 32'h0, 4'h0, 3'd1, 1);
    drain("drain_timeout");
    check("to_access_cycles", acc_seen, TO);
    check("to_flags", {last_err, last_to}, 2'b11);

    // PREADY on the last allowed cycle wins over the timeout.
    sl_wait = TO - 1;
    issue(1, 32'h0000_0804, 1'b0, 32'h0, 4'h0, 3'd0, 1);
    drain("drain_late_ready");
    check("late_access_cycles", acc_seen, TO);
    check("late_flags", {last_err, last_to}, 2'b00);

    // Slave error with PREADY, and PSLVERR noise while waiting.
    sl_wait = 0; sl_err = 1;
    issue(0, 32'h0000_0C00, 1'b1, 32'hCAFE_F00D, 4'h5, 3'd3, 1);
    drain("drain_slverr");
    check("slverr_flags", {last_err, last_to}, 2'b10);
    sl_wait = 2; sl_err = 0; sl_noise_err = 1'b1;
    issue(1, 32'h0000_0C04, 1'b0, 32'h0, 4'h0, 3'd0, 1);
    drain("drain_noise");
    check("noise_flags", {last_err, last_to}, 2'b00);
    sl_noise_err = 1'b0;

    // Randomized traffic.
    sl_wait = -1; sl_err = -1;
    fork
      run_rand(0, 25, 3);
      run_rand(1, 25, 3);
    join
    drain("drain_random");

    // Reset in the middle of ACCESS.
    sl_wait = 99;
    issue(1, AW'($urandom), 1'b0, DW'($urandom), 4'hF, 3'd0, 1);
    c = 0;
    while (!bus.PENABLE && c < 50) begin
      @(negedge PCLK);
      c++;
    end
    if (c >= 50) bound_fail("reach_access");
    repeat (3) @(posedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_now_psel", {bus.PSELx, bus.PENABLE}, 2'b00);
    check("rst_now_rsp", bus.rsp_valid, '0);
    check("rst_now_paddr", bus.PADDR, '0);
    check("rst_now_state", dbg_state, 2'd0);
    @(posedge PCLK); #1;
    for (int i = 0; i < NR; i++) begin
      cur_addr[i]  = AW'($urandom);
      cur_wdata[i] = DW'($urandom);
      cur_write[i] = 1'($urandom);
      cur_valid[i] = 1'b1;
    end
    sl_wait = 0;
    grant_log.delete();
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    c = 0;
    while (grant_log.size() == 0 && c < 20) begin
      @(negedge PCLK);
      c++;
    end
    if (grant_log.size() == 0) bound_fail("post_reset_grant");
    else check("post_reset_first", grant_log[0], 0);
    @(posedge PCLK); #1;
    for (int i = 0; i < NR; i++) cur_valid[i] = 1'b0;
    drain("drain_post_reset");

    repeat (3) @(posedge PCLK);
    check("rsp_count", n_rsp_seen, n_grants - n_aborted);
    check("exp_q_empty", exp_q.size(), 0);
    summary();
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    summary();
    $fatal(1, "watchdog");
  end
endmodule
